// File: rtl/llc_snoop_responder_pkg.sv
// Shared LLC cache definitions: geometry, MESI/snoop encodings, bus ops, L1 messages.
package llc_snoop_responder_pkg;

  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned OFS_W    = 6;
  localparam int unsigned NB_INDEX = 15;
  localparam int unsigned NB_TAG   = 11;
  localparam int unsigned WAYS     = 8;
  localparam int unsigned WAY_W    = 3;
  localparam int unsigned LINE_W   = ADDR_W - OFS_W;

  typedef enum logic [1:0] {
    MESI_M = 2'd0,
    MESI_E = 2'd1,
    MESI_S = 2'd2,
    MESI_I = 2'd3
  } mesi_t;

  typedef enum logic [1:0] {
    SNP_NOHIT = 2'd0,
    SNP_HIT   = 2'd1,
    SNP_HITM  = 2'd2
  } snoop_t;

  localparam logic [2:0] BUS_READ       = 3'd1;
  localparam logic [2:0] BUS_WRITE      = 3'd2;
  localparam logic [2:0] BUS_INVALIDATE = 3'd3;
  localparam logic [2:0] BUS_RWIM       = 3'd4;

  localparam logic [2:0] L1_GETLINE        = 3'd1;
  localparam logic [2:0] L1_INVALIDATELINE = 3'd3;

  // Work list decided at compare time for one snoop
  typedef struct packed {
    snoop_t             snoop;
    logic               err;
    logic               getl;
    logic               flush;
    logic               invl;
    logic               upd;
    logic [WAY_W-1:0]   way;
    mesi_t              new_mesi;
  } snp_plan_t;

endpackage

// File: rtl/llc_way_match.sv
// Combinational tag/MESI compare across all ways; lowest matching way wins.
module llc_way_match
  import llc_snoop_responder_pkg::*;
(
  input  logic [NB_TAG-1:0]      tag,
  input  logic [WAYS*NB_TAG-1:0] rd_tag,
  input  logic [WAYS*2-1:0]      rd_mesi,
  output logic                   hit,
  output logic [WAY_W-1:0]       hit_way,
  output mesi_t                  hit_mesi,
  output logic                   multi_hit
);

  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    hit_mesi  = MESI_I;
    multi_hit = 1'b0;
    for (int unsigned i = 0; i < WAYS; i++) begin
      if ((rd_tag[i*NB_TAG +: NB_TAG] == tag) && (rd_mesi[i*2 +: 2] != MESI_I)) begin
        if (hit) begin
          multi_hit = 1'b1;
        end else begin
          hit      = 1'b1;
          hit_way  = WAY_W'(i);
          hit_mesi = mesi_t'(rd_mesi[i*2 +: 2]);
        end
      end
    end
  end

endmodule

// File: rtl/llc_snoop_responder.sv
// Snoop responder for the 8-way MESI LLC: lookup, snoop result, L1 recall,
// modified-line flush and MESI downgrade/invalidate.
module llc_snoop_responder
  import llc_snoop_responder_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   snp_valid,
  output logic                   snp_ready,
  input  logic [2:0]             snp_op,
  input  logic [ADDR_W-1:0]      snp_addr,
  output logic                   ta_rd_en,
  output logic [NB_INDEX-1:0]    ta_set,
  input  logic [WAYS*NB_TAG-1:0] ta_rd_tag,
  input  logic [WAYS*2-1:0]      ta_rd_mesi,
  output logic                   ta_wr_en,
  output logic [WAY_W-1:0]       ta_wr_way,
  output logic [1:0]             ta_wr_mesi,
  output logic                   l1_msg_valid,
  input  logic                   l1_msg_ack,
  output logic [2:0]             l1_msg,
  output logic [ADDR_W-1:0]      l1_msg_addr,
  output logic                   wb_req,
  input  logic                   wb_done,
  output logic [ADDR_W-1:0]      wb_addr,
  output logic                   res_valid,
  output logic [1:0]             res_snoop,
  output logic                   err
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_COMPARE, S_GETL, S_FLUSH, S_INVL, S_UPDATE, S_RESP
  } state_t;

  state_t              state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic [LINE_W-1:0]   line_q, line_d;
  snp_plan_t           plan_q, plan_d;

  logic                snp_ready_q, snp_ready_d;
  logic                ta_rd_en_q, ta_rd_en_d;
  logic [NB_INDEX-1:0] ta_set_q, ta_set_d;
  logic                ta_wr_en_q, ta_wr_en_d;
  logic [WAY_W-1:0]    ta_wr_way_q, ta_wr_way_d;
  mesi_t               ta_wr_mesi_q, ta_wr_mesi_d;
  logic                l1_msg_valid_q, l1_msg_valid_d;
  logic [2:0]          l1_msg_q, l1_msg_d;
  logic [ADDR_W-1:0]   l1_msg_addr_q, l1_msg_addr_d;
  logic                wb_req_q, wb_req_d;
  logic [ADDR_W-1:0]   wb_addr_q, wb_addr_d;
  logic                res_valid_q, res_valid_d;
  snoop_t              res_snoop_q, res_snoop_d;
  logic                err_q, err_d;

  logic                hit;
  logic [WAY_W-1:0]    hit_way;
  mesi_t               hit_mesi;
  logic                multi_hit;

  // Snoops are line-granular; the byte offset is never used
  logic                unused_offset;
  assign unused_offset = ^snp_addr[OFS_W-1:0];

  llc_way_match u_way_match (
    .tag       (line_q[LINE_W-1 -: NB_TAG]),
    .rd_tag    (ta_rd_tag),
    .rd_mesi   (ta_rd_mesi),
    .hit       (hit),
    .hit_way   (hit_way),
    .hit_mesi  (hit_mesi),
    .multi_hit (multi_hit)
  );

  // Snoop result and required actions for one op / hit-state combination
  function automatic snp_plan_t build_plan(input logic [2:0] op, input logic h,
                                           input mesi_t m, input logic [WAY_W-1:0] way,
                                           input logic multi);
    snp_plan_t p;
    p          = '0;
    p.snoop    = SNP_NOHIT;
    p.way      = way;
    p.new_mesi = m;
    p.err      = multi;
    case (op)
      BUS_READ: if (h) begin
        p.snoop    = (m == MESI_M) ? SNP_HITM : SNP_HIT;
        p.getl     = (m == MESI_M);
        p.flush    = (m == MESI_M);
        p.new_mesi = MESI_S;
      end
      BUS_RWIM: if (h) begin
        p.snoop    = (m == MESI_M) ? SNP_HITM : SNP_HIT;
        p.getl     = (m == MESI_M);
        p.flush    = (m == MESI_M);
        p.invl     = 1'b1;
        p.new_mesi = MESI_I;
      end
      BUS_INVALIDATE: if (h) begin
        if (m == MESI_S) begin
          p.invl     = 1'b1;
          p.new_mesi = MESI_I;
        end else begin
          p.err = 1'b1;
        end
      end
      BUS_WRITE: if (h) p.err = 1'b1;
      default:   p.err = 1'b1;
    endcase
    p.upd = h && (p.new_mesi != m);
    return p;
  endfunction

  // Next required downstream state after 'from', in fixed GETL/FLUSH/INVL/UPDATE/RESP order
  function automatic state_t next_after(input state_t from, input snp_plan_t p);
    state_t n;
    n = S_RESP;
    if (p.upd) n = S_UPDATE;
    if (p.invl && (from != S_INVL)) n = S_INVL;
    if (p.flush && ((from == S_COMPARE) || (from == S_GETL))) n = S_FLUSH;
    if (p.getl && (from == S_COMPARE)) n = S_GETL;
    return n;
  endfunction

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    line_d  = line_q;
    plan_d  = plan_q;

    case (state_q)
      S_IDLE: if (snp_valid) begin
        op_d    = snp_op;
        line_d  = snp_addr[ADDR_W-1:OFS_W];
        state_d = S_LOOKUP;
      end
      S_LOOKUP:  state_d = S_COMPARE;
      S_COMPARE: begin
        plan_d  = build_plan(op_q, hit, hit_mesi, hit_way, multi_hit);
        state_d = next_after(S_COMPARE, plan_d);
      end
      S_GETL:    if (l1_msg_ack) state_d = next_after(S_GETL, plan_q);
      S_FLUSH:   if (wb_done)    state_d = next_after(S_FLUSH, plan_q);
      S_INVL:    if (l1_msg_ack) state_d = next_after(S_INVL, plan_q);
      S_UPDATE:  state_d = S_RESP;
      S_RESP:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase

    // Registered outputs follow the state being entered
    snp_ready_d    = (state_d == S_IDLE);
    ta_rd_en_d     = (state_d == S_LOOKUP);
    ta_set_d       = line_d[NB_INDEX-1:0];
    ta_wr_en_d     = (state_d == S_UPDATE);
    ta_wr_way_d    = ta_wr_en_d ? plan_d.way : '0;
    ta_wr_mesi_d   = ta_wr_en_d ? plan_d.new_mesi : MESI_M;
    l1_msg_valid_d = (state_d == S_GETL) || (state_d == S_INVL);
    l1_msg_d       = (state_d == S_GETL) ? L1_GETLINE :
                     (state_d == S_INVL) ? L1_INVALIDATELINE : 3'd0;
    l1_msg_addr_d  = l1_msg_valid_d ? {line_d, OFS_W'(0)} : '0;
    wb_req_d       = (state_d == S_FLUSH);
    wb_addr_d      = wb_req_d ? {line_d, OFS_W'(0)} : '0;
    res_valid_d    = (state_d == S_RESP);
    res_snoop_d    = res_valid_d ? plan_d.snoop : SNP_NOHIT;
    err_d          = res_valid_d && plan_d.err;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      op_q           <= '0;
      line_q         <= '0;
      plan_q         <= '0;
      snp_ready_q    <= 1'b1;
      ta_rd_en_q     <= 1'b0;
      ta_set_q       <= '0;
      ta_wr_en_q     <= 1'b0;
      ta_wr_way_q    <= '0;
      ta_wr_mesi_q   <= MESI_M;
      l1_msg_valid_q <= 1'b0;
      l1_msg_q       <= '0;
      l1_msg_addr_q  <= '0;
      wb_req_q       <= 1'b0;
      wb_addr_q      <= '0;
      res_valid_q    <= 1'b0;
      res_snoop_q    <= SNP_NOHIT;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      op_q           <= op_d;
      line_q         <= line_d;
      plan_q         <= plan_d;
      snp_ready_q    <= snp_ready_d;
      ta_rd_en_q     <= ta_rd_en_d;
      ta_set_q       <= ta_set_d;
      ta_wr_en_q     <= ta_wr_en_d;
      ta_wr_way_q    <= ta_wr_way_d;
      ta_wr_mesi_q   <= ta_wr_mesi_d;
      l1_msg_valid_q <= l1_msg_valid_d;
      l1_msg_q       <= l1_msg_d;
      l1_msg_addr_q  <= l1_msg_addr_d;
      wb_req_q       <= wb_req_d;
      wb_addr_q      <= wb_addr_d;
      res_valid_q    <= res_valid_d;
      res_snoop_q    <= res_snoop_d;
      err_q          <= err_d;
    end
  end

  assign snp_ready    = snp_ready_q;
  assign ta_rd_en     = ta_rd_en_q;
  assign ta_set       = ta_set_q;
  assign ta_wr_en     = ta_wr_en_q;
  assign ta_wr_way    = ta_wr_way_q;
  assign ta_wr_mesi   = ta_wr_mesi_q;
  assign l1_msg_valid = l1_msg_valid_q;
  assign l1_msg       = l1_msg_q;
  assign l1_msg_addr  = l1_msg_addr_q;
  assign wb_req       = wb_req_q;
  assign wb_addr      = wb_addr_q;
  assign res_valid    = res_valid_q;
  assign res_snoop    = res_snoop_q;
  assign err          = err_q;

endmodule
